// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: MEM -> WB stage. Selects the writeback source, waits
// for load data when needed, extracts/extends the loaded value and drives
// a single register-file write port.
// Optional feature: define WB_WRITEBACK_FWD_EN to mirror the write port
// onto fwd_* for the EX-stage bypass; otherwise fwd_* are tied to 0.
module wb_writeback_unit #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       wb_sel_i,
  input  logic             is_load_i,
  input  logic [2:0]       size_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [RF_AW-1:0] rd_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  pc4_i,
  input  logic [XLEN-1:0]  csr_rdata_i,
  input  logic             rvalid_i,
  input  logic [XLEN-1:0]  rdata_i,
  input  logic             flush_i,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             fwd_valid_o,
  output logic [RF_AW-1:0] fwd_rd_o,
  output logic [XLEN-1:0]  fwd_data_o
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN, WRITE} state_e;

  state_e           state_q, state_d;
  logic [RF_AW-1:0] rd_q, rd_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  // Last values written; presented while no write is happening.
  logic [RF_AW-1:0] waddr_hold_q;
  logic [XLEN-1:0]  wdata_hold_q;

  logic            accept;
  logic            we;
  logic [XLEN-1:0] sel_data;

  // Byte/half/word extraction from the low 32 bits of the load data.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d,
                                              input logic [2:0]      sz,
                                              input logic [1:0]      a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = d[31:0];
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  extract = XLEN'($signed(b));
      3'b001:  extract = XLEN'($signed(h));
      3'b010:  extract = XLEN'($signed(w));
      3'b100:  extract = XLEN'(b);
      3'b101:  extract = XLEN'(h);
      default: extract = XLEN'(w);
    endcase
  endfunction

  assign ready_o = (state_q == IDLE) || (state_q == WRITE);
  assign accept  = valid_i && ready_o;

  // Writeback source mux for non-load instructions.
  always_comb begin
    case (wb_sel_i)
      2'd2:    sel_data = pc4_i;
      2'd3:    sel_data = csr_rdata_i;
      default: sel_data = alu_result_i;
    endcase
  end

  // Next-state, capture and write-enable logic.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we      = 1'b0;
    case (state_q)
      IDLE: ;
      WRITE: begin
        we      = (rd_q != '0) && !flush_i;
        state_d = IDLE;
      end
      WAIT_LOAD: begin
        if (flush_i) begin
          state_d = rvalid_i ? IDLE : DRAIN;
        end else if (rvalid_i) begin
          data_d  = extract(rdata_i, size_q, addr_q);
          state_d = WRITE;
        end
      end
      DRAIN: begin
        if (rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // accept only happens in IDLE/WRITE, so it overrides the above
    if (accept) begin
      rd_d = rd_i;
      if (is_load_i) begin
        size_d  = size_i;
        addr_d  = addr_lo_i;
        state_d = WAIT_LOAD;
      end else begin
        data_d  = sel_data;
        state_d = WRITE;
      end
    end
  end

  // State and capture registers, plus hold copies of the write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      size_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      waddr_hold_q <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (we) begin
        waddr_hold_q <= rd_q;
        wdata_hold_q <= data_q;
      end
    end
  end

  assign rf_we_o    = we;
  assign rf_waddr_o = we ? rd_q   : waddr_hold_q;
  assign rf_wdata_o = we ? data_q : wdata_hold_q;

`ifdef WB_WRITEBACK_FWD_EN
  assign fwd_valid_o = rf_we_o;
  assign fwd_rd_o    = rf_waddr_o;
  assign fwd_data_o  = rf_wdata_o;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_rd_o    = '0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit: drivers push expected writes
// (register, value, cycle) and an independent monitor pops and compares.
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  wb_sel = '0;
  logic        is_load = 1'b0;
  logic [2:0]  size = '0;
  logic [1:0]  addr_lo = '0;
  logic [4:0]  rd = '0;
  logic [31:0] alu = '0, pc4 = '0, csr = '0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        flush = 1'b0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  wb_writeback_unit #(.XLEN(32), .RF_AW(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .wb_sel_i(wb_sel), .is_load_i(is_load), .size_i(size), .addr_lo_i(addr_lo),
    .rd_i(rd), .alu_result_i(alu), .pc4_i(pc4), .csr_rdata_i(csr),
    .rvalid_i(rvalid), .rdata_i(rdata), .flush_i(flush),
    .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load formatting from the byte-lane rules.
  function automatic logic [31:0] load_ref(input logic [31:0] d, input logic [2:0] sz,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    case (sz)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // Monitor: every cycle, either a write matching the scoreboard head or held outputs.
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (we) begin
        if (sb.size() == 0) chk("unexpected_write", {27'd0, waddr}, 64'hDEAD);
        else begin
          e = sb.pop_front();
          chk("waddr", waddr, e.rd);
          chk("wdata", wdata, e.data);
          chk("write_cycle", cyc, e.cyc);
          last_addr = e.rd;
          last_data = e.data;
`ifdef WB_WRITEBACK_FWD_EN
          chk("fwd_valid", fwd_valid, 1);
          chk("fwd_rd", fwd_rd, e.rd);
          chk("fwd_data", fwd_data, e.data);
`endif
        end
      end else begin
        chk("hold_waddr", waddr, last_addr);
        chk("hold_wdata", wdata, last_data);
`ifdef WB_WRITEBACK_FWD_EN
        chk("fwd_valid_idle", fwd_valid, 0);
`endif
      end
`ifndef WB_WRITEBACK_FWD_EN
      chk("fwd_tied", {fwd_valid, fwd_rd, fwd_data}, 0);
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with stray rvalid pulses that must be ignored outside a load.
  task automatic gap(input int n);
    repeat (n) begin
      rvalid = 1'($urandom);
      rdata  = $urandom;
      tick();
      rvalid = 1'b0;
      flush  = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      flush = 1'b0;
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  // Non-load instruction; kill flushes it in its write cycle.
  task automatic issue_op(input logic [1:0] sel, input logic [31:0] v, input logic [4:0] r,
                          input bit kill);
    wait_ready();
    valid = 1'b1; is_load = 1'b0; wb_sel = sel; rd = r;
    alu = $urandom; pc4 = $urandom; csr = $urandom;
    case (sel)
      2'd1: alu = v;
      2'd2: pc4 = v;
      default: csr = v;
    endcase
    if (r != 0 && !kill) sb.push_back('{r, v, cyc + 1});
    tick();
    valid = 1'b0;
    flush = kill;
  endtask

  // Load: mode 0 normal, 1 flush then drained response, 2 flush with response.
  task automatic do_load(input logic [4:0] r, input logic [2:0] sz, input logic [1:0] off,
                         input int lat, input logic [31:0] d, input int mode);
    wait_ready();
    valid = 1'b1; is_load = 1'b1; rd = r; size = sz; addr_lo = off;
    wb_sel = 2'($urandom);
    tick();
    valid = 1'b0; is_load = 1'b0; flush = 1'b0;
    repeat (lat) begin
      chk("ready_in_wait", ready, 0);
      tick();
    end
    case (mode)
      0: begin
        rvalid = 1'b1; rdata = d;
        if (r != 0) sb.push_back('{r, load_ref(d, sz, off), cyc + 1});
        tick();
      end
      1: begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("ready_in_drain", ready, 0);
        rvalid = 1'b1; rdata = d;
        tick();
      end
      default: begin
        flush = 1'b1; rvalid = 1'b1; rdata = d;
        tick();
      end
    endcase
    rvalid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    issue_op(2'd1, 32'h0000_1234, 5'd5, 0);
    gap(2);
    do_load(5'd7, 3'b000, 2'd2, 3, 32'h0080_0000, 0);
    gap(1);
    do_load(5'd9, 3'b101, 2'd3, 1, 32'hBEEF_0000, 0);
    gap(1);
    issue_op(2'd2, 32'h0000_0104, 5'd0, 0);
    gap(2);
    do_load(5'd11, 3'b010, 2'd0, 2, 32'h1357_9BDF, 1);
    issue_op(2'd3, 32'hCAFE_F00D, 5'd12, 0);
    gap(1);
    // back-to-back, then flush in WRITE with a same-cycle accept
    issue_op(2'd1, 32'h1111_1111, 5'd1, 0);
    issue_op(2'd1, 32'h2222_2222, 5'd2, 0);
    issue_op(2'd2, 32'h3333_3333, 5'd3, 1);
    issue_op(2'd3, 32'h4444_4444, 5'd4, 0);
    gap(1);
    do_load(5'd13, 3'b001, 2'd1, 0, 32'h0000_8000, 2);
    gap(1);

    // reset mid-load: outputs drop at once, later response ignored
    valid = 1'b1; is_load = 1'b1; rd = 5'd14; size = 3'b010;
    tick();
    valid = 1'b0; is_load = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_waddr", waddr, 0);
    chk("midrst_wdata", wdata, 0);
    chk("midrst_ready", ready, 1);
    last_addr = '0;
    last_data = '0;
    tick();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'h7777_7777;
    tick();
    rvalid = 1'b0;
    gap(2);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        int m;
        m = $urandom_range(7);
        do_load(5'($urandom), 3'($urandom), 2'($urandom), $urandom_range(3), $urandom,
                (m < 5) ? 0 : (m == 5) ? 1 : 2);
      end else begin
        issue_op(2'($urandom_range(3, 1)), $urandom,
                 ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom_range(5) == 0);
      end
      if ($urandom_range(1) == 0) gap($urandom_range(2));
    end

    gap(4);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_writeback_unit.md
WB_WRITEBACK_UNIT -- requirements
Module: wb_writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a multiple of 32.
REQ-002 Parameter RF_AW, default 5, register-file address width.
REQ-003 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 valid_i  in  1  MEM-stage instruction valid.
REQ-006 ready_o  out  1  unit can accept an instruction this cycle.
REQ-007 wb_sel_i  in  2  source: 0 load, 1 alu_result_i, 2 pc4_i, 3 csr_rdata_i.
REQ-008 is_load_i  in  1  instruction waits for a load response.
REQ-009 size_i  in  3  load format: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 addr_lo_i  in  2  load byte offset.
REQ-011 rd_i  in  RF_AW  destination register.
REQ-012 alu_result_i, pc4_i, csr_rdata_i  in  XLEN  writeback candidates.
REQ-013 rvalid_i  in  1  load data valid; rdata_i  in  XLEN  load data.
REQ-014 flush_i  in  1  kill the instruction held by the unit.
REQ-015 rf_we_o  out  1, rf_waddr_o  out  RF_AW, rf_wdata_o  out  XLEN  register-file write port.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_LOAD, DRAIN, WRITE.
REQ-017 Accept SHALL occur when valid_i && ready_o; ready_o SHALL be 1 in IDLE and WRITE, 0 in WAIT_LOAD and DRAIN.
REQ-018 Non-load accept SHALL capture the selected source and rd_i, then go to WRITE; rf_we_o SHALL be 1 exactly one cycle after accept.
REQ-019 Load accept (is_load_i=1) SHALL capture rd_i, size_i, addr_lo_i and go to WAIT_LOAD; rvalid_i SHALL be ignored outside WAIT_LOAD and DRAIN.
REQ-020 In WAIT_LOAD, rvalid_i=1 SHALL capture the extracted data and go to WRITE; rf_we_o SHALL be 1 the cycle after rvalid_i.
REQ-021 Extraction: byte = rdata_i[8*addr_lo_i+:8]; half = rdata_i[16*addr_lo_i[1]+:16] (addr_lo_i[0] ignored); LB/LH sign-extend, LBU/LHU zero-extend, LW and undefined codes pass rdata_i[31:0].
REQ-022 For XLEN>32, LW SHALL sign-extend bit 31; other sources pass unchanged.
REQ-023 In WRITE, rf_we_o SHALL be 1 unless the captured rd is 0; a simultaneous new accept SHALL go to WRITE or WAIT_LOAD, else IDLE.
REQ-024 rf_we_o SHALL be 1 for at most one cycle per accepted instruction.
REQ-025 flush_i in WRITE SHALL force rf_we_o to 0 that cycle; an accept in the same cycle SHALL proceed normally.
REQ-026 flush_i in WAIT_LOAD SHALL go to DRAIN (or IDLE if rvalid_i=1 that cycle); DRAIN SHALL discard the next rvalid_i and return to IDLE.
REQ-027 rf_waddr_o/rf_wdata_o SHALL hold their last values while rf_we_o=0.

Reset
REQ-028 rst_ni=0 SHALL immediately force state IDLE, rf_we_o 0, rf_waddr_o 0, rf_wdata_o 0, ready_o 1.
REQ-029 Reset during WAIT_LOAD or DRAIN SHALL drop the pending load; a later rvalid_i SHALL be ignored.

Configuration
REQ-030 Macro WB_WRITEBACK_FWD_EN SHALL enable outputs fwd_valid_o (1), fwd_rd_o (RF_AW), fwd_data_o (XLEN).
REQ-031 With the macro defined, fwd_* SHALL combinationally equal rf_we_o/rf_waddr_o/rf_wdata_o for the EX-stage bypass.
REQ-032 Without the macro, the fwd_* ports SHALL exist and be tied to 0.

Verification
REQ-033 ALU: accept wb_sel=1, alu=0x0000_1234, rd=5 -> next cycle we=1, waddr=5, wdata=0x0000_1234, one cycle only.
REQ-034 LB: accept load size=000, addr_lo=2, rd=7; 3 cycles later rvalid with rdata=0x0080_0000 -> next cycle wdata=0xFFFF_FF80, we=1; ready_o=0 while waiting.
REQ-035 LHU: size=101, addr_lo=3, rdata=0xBEEF_0000 -> wdata=0x0000_BEEF.
REQ-036 rd=0: accept wb_sel=2, pc4=0x104, rd=0 -> we stays 0.
REQ-037 Flush in WAIT_LOAD, then rvalid -> no write; next accept with wb_sel=3 -> normal write one cycle later.
REQ-038 Back-to-back: accepts in consecutive cycles with rd=1,2 -> we=1 on two consecutive cycles with matching waddr; rst_ni low mid-load -> outputs 0 at once.
